cache_fsm_controller: RTL and testbench

Sequential successor to the combinational cache way/set controller. Controls an N-way set-associative, write-through cache with its own per-line valid bits, miss handling, multi-beat block refill and write-through to memory over valid/ready handshakes. Sits between the CPU load/store port, the tag/data arrays plus the replacement unit (CRU), and the memory bus.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_victim_select.sv | 21 ++
 rtl/cache_fsm_controller.sv | 213 +++++++++++++++++++++
 tb/tb_cache_fsm_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, default geometry and width helpers for the cache controller.
package cache_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_DATA,
    WT_REQ,
    WT_WAIT,
    RESPOND
  } cache_state_t;

  localparam int unsigned DEF_ADDR_SIZE       = 32;
  localparam int unsigned DEF_NUM_SETS        = 16;
  localparam int unsigned DEF_NUM_WAYS        = 4;
  localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
  localparam int unsigned BYTE_OFF_W          = 2;

  // Way index width; a direct-mapped cache still carries a 1-bit way index
  function automatic int unsigned way_width(input int unsigned num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  // Tag width left over once set, word and byte offsets are removed
  function automatic int unsigned tag_width(input int unsigned addr_size,
                                            input int unsigned num_sets,
                                            input int unsigned words_per_block);
    return addr_size - $clog2(num_sets) - $clog2(words_per_block) - BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Refill victim choice: lowest invalid way, otherwise the replacement unit's pick.
module cache_victim_select
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = DEF_NUM_WAYS,
  parameter int unsigned WAY_W    = way_width(DEF_NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    replace_way_i,
  output logic [WAY_W-1:0]    victim_way_o
);

  // Scan downward so the lowest invalid way wins
  always_comb begin
    victim_way_o = replace_way_i;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_way_o = WAY_W'(i);
    end
  end

endmodule

// File: rtl/cache_fsm_controller.sv
// Write-through set-associative cache controller: lookup, block refill, write-through.
module cache_fsm_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_SIZE       = DEF_ADDR_SIZE,
  parameter int unsigned NUM_SETS        = DEF_NUM_SETS,
  parameter int unsigned NUM_WAYS        = DEF_NUM_WAYS,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned WRITE_ALLOCATE  = 1,
  localparam int unsigned WAY_W          = way_width(NUM_WAYS),
  localparam int unsigned SET_W          = $clog2(NUM_SETS),
  localparam int unsigned WORD_W         = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  output logic                 cpu_resp_valid,
  output logic                 cpu_resp_hit,
  input  logic                 flush,
  input  logic [NUM_WAYS-1:0]  tag_match,
  input  logic [WAY_W-1:0]     replace_way,
  output logic                 cru_enable,
  output logic [WAY_W-1:0]     cru_way,
  output logic [SET_W-1:0]     array_set,
  output logic [WAY_W-1:0]     array_way,
  output logic [WORD_W-1:0]    array_word,
  output logic                 array_we,
  output logic                 array_src_mem,
  output logic                 tag_we,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [ADDR_SIZE-1:0] mem_req_addr,
  input  logic                 mem_rdata_valid,
  input  logic                 mem_wr_done
);

  localparam int unsigned TAG_W = tag_width(ADDR_SIZE, NUM_SETS, WORDS_PER_BLOCK);

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [SET_W-1:0]      set;
    logic [WORD_W-1:0]     word;
    logic [BYTE_OFF_W-1:0] byte_off;
  } cache_addr_t;

  cache_state_t                         state_q, state_d;
  cache_addr_t                          addr_q, addr_d;
  logic                                 we_q, we_d;
  logic                                 miss_q, miss_d;
  logic [WAY_W-1:0]                     victim_q, victim_d;
  logic [WORD_W-1:0]                    beat_q, beat_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]    valid_q, valid_d;

  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim_way;
  logic                unused_byte_off;

  // Byte lanes are resolved outside the controller
  assign unused_byte_off = ^addr_q.byte_off;

  // Hit detection against the latched set; lowest matching way wins
  always_comb begin
    hit_vec = tag_match & valid_q[addr_q.set];
    hit     = |hit_vec;
    hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
    end
  end

  cache_victim_select #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim (
    .valid_i       (valid_q[addr_q.set]),
    .replace_way_i (replace_way),
    .victim_way_o  (victim_way)
  );

  // State and per-transaction context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      miss_q   <= 1'b0;
      victim_q <= '0;
      beat_q   <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      miss_q   <= miss_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    we_d           = we_q;
    miss_d         = miss_q;
    victim_d       = victim_q;
    beat_d         = beat_q;
    valid_d        = valid_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_hit   = 1'b0;
    cru_enable     = 1'b0;
    cru_way        = '0;
    array_set      = addr_q.set;
    array_way      = '0;
    array_word     = '0;
    array_we       = 1'b0;
    array_src_mem  = 1'b0;
    tag_we         = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;

    unique case (state_q)
      IDLE: begin
        cpu_req_ready = !flush;
        if (flush) begin
          valid_d = '0;
        end else if (cpu_req_valid) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          miss_d  = 1'b0;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          cru_enable = 1'b1;
          cru_way    = hit_way;
          if (we_q) begin
            array_we      = 1'b1;
            array_src_mem = 1'b0;
            array_way     = hit_way;
            array_word    = addr_q.word;
            state_d       = WT_REQ;
          end else begin
            state_d = RESPOND;
          end
        end else begin
          miss_d = 1'b1;
          if (we_q && (WRITE_ALLOCATE == 0)) begin
            state_d = WT_REQ;
          end else begin
            victim_d = victim_way;
            state_d  = REFILL_REQ;
          end
        end
      end

      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q.tag, addr_q.set, {(WORD_W + BYTE_OFF_W){1'b0}}};
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = REFILL_DATA;
        end
      end

      REFILL_DATA: begin
        array_way  = victim_q;
        array_word = beat_q;
        if (mem_rdata_valid) begin
          array_we      = 1'b1;
          array_src_mem = 1'b1;
          beat_d        = beat_q + WORD_W'(1);
          if (beat_q == WORD_W'(WORDS_PER_BLOCK - 1)) begin
            tag_we                       = 1'b1;
            valid_d[addr_q.set][victim_q] = 1'b1;
            state_d                      = LOOKUP;
          end
        end
      end

      WT_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {addr_q.tag, addr_q.set, addr_q.word, {BYTE_OFF_W{1'b0}}};
        if (mem_req_ready) state_d = WT_WAIT;
      end

      WT_WAIT: begin
        if (mem_wr_done) state_d = RESPOND;
      end

      RESPOND: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_hit   = !miss_q;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fsm_controller.sv
// Directed bench for cache_fsm_controller with a small tag-array model and scoreboard queues.
module tb_cache_fsm_controller;

  logic        clk;
  logic        rst_n;
  logic        m_req_valid, n_req_valid;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        flush;
  logic [3:0]  tag_match;
  logic [1:0]  replace_way;
  logic        mem_req_ready;
  logic        mem_rdata_valid;
  logic        mem_wr_done;

  // Outputs of the write-allocate instance (m_) and the no-allocate instance (n_)
  logic        m_ready, m_resp_valid, m_resp_hit, m_cru, m_array_we, m_src_mem, m_tag_we;
  logic        m_mem_valid, m_mem_we;
  logic [1:0]  m_cru_way, m_array_way;
  logic [3:0]  m_array_set;
  logic [2:0]  m_array_word;
  logic [31:0] m_mem_addr;
  logic        n_ready, n_resp_valid, n_resp_hit, n_cru, n_array_we, n_src_mem, n_tag_we;
  logic        n_mem_valid, n_mem_we;
  logic [1:0]  n_cru_way, n_array_way;
  logic [3:0]  n_array_set;
  logic [2:0]  n_array_word;
  logic [31:0] n_mem_addr;

  logic        sel_nwa;
  logic        o_ready, o_resp_valid, o_resp_hit, o_cru, o_array_we, o_src_mem, o_tag_we;
  logic        o_mem_valid, o_mem_we;
  logic [1:0]  o_cru_way, o_array_way;
  logic [3:0]  o_array_set;
  logic [2:0]  o_array_word;
  logic [31:0] o_mem_addr;

  logic [31:0] cur_addr;
  logic [22:0] tag_mdl [16][4];
  logic [15:0][3:0] tag_vld = '0;

  bit          resp_q[$];
  logic [32:0] mem_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  cache_fsm_controller #(.WRITE_ALLOCATE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(m_req_valid), .cpu_req_ready(m_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_resp_valid(m_resp_valid), .cpu_resp_hit(m_resp_hit), .flush(flush),
    .tag_match(tag_match), .replace_way(replace_way), .cru_enable(m_cru), .cru_way(m_cru_way),
    .array_set(m_array_set), .array_way(m_array_way), .array_word(m_array_word),
    .array_we(m_array_we), .array_src_mem(m_src_mem), .tag_we(m_tag_we),
    .mem_req_valid(m_mem_valid), .mem_req_ready(mem_req_ready), .mem_req_we(m_mem_we),
    .mem_req_addr(m_mem_addr), .mem_rdata_valid(mem_rdata_valid), .mem_wr_done(mem_wr_done)
  );

  cache_fsm_controller #(.WRITE_ALLOCATE(0)) u_dut_nwa (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(n_req_valid), .cpu_req_ready(n_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_resp_valid(n_resp_valid), .cpu_resp_hit(n_resp_hit), .flush(flush),
    .tag_match(tag_match), .replace_way(replace_way), .cru_enable(n_cru), .cru_way(n_cru_way),
    .array_set(n_array_set), .array_way(n_array_way), .array_word(n_array_word),
    .array_we(n_array_we), .array_src_mem(n_src_mem), .tag_we(n_tag_we),
    .mem_req_valid(n_mem_valid), .mem_req_ready(mem_req_ready), .mem_req_we(n_mem_we),
    .mem_req_addr(n_mem_addr), .mem_rdata_valid(mem_rdata_valid), .mem_wr_done(mem_wr_done)
  );

  assign o_ready      = sel_nwa ? n_ready      : m_ready;
  assign o_resp_valid = sel_nwa ? n_resp_valid : m_resp_valid;
  assign o_resp_hit   = sel_nwa ? n_resp_hit   : m_resp_hit;
  assign o_cru        = sel_nwa ? n_cru        : m_cru;
  assign o_cru_way    = sel_nwa ? n_cru_way    : m_cru_way;
  assign o_array_set  = sel_nwa ? n_array_set  : m_array_set;
  assign o_array_way  = sel_nwa ? n_array_way  : m_array_way;
  assign o_array_word = sel_nwa ? n_array_word : m_array_word;
  assign o_array_we   = sel_nwa ? n_array_we   : m_array_we;
  assign o_src_mem    = sel_nwa ? n_src_mem    : m_src_mem;
  assign o_tag_we     = sel_nwa ? n_tag_we     : m_tag_we;
  assign o_mem_valid  = sel_nwa ? n_mem_valid  : m_mem_valid;
  assign o_mem_we     = sel_nwa ? n_mem_we     : m_mem_we;
  assign o_mem_addr   = sel_nwa ? n_mem_addr   : m_mem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag array model: tag_we stores the requesting tag into the addressed set/way
  always_ff @(posedge clk) begin
    if (o_tag_we) begin
      tag_mdl[o_array_set][o_array_way] <= cur_addr[31:9];
      tag_vld[o_array_set][o_array_way] <= 1'b1;
    end
  end

  // Per-way tag compare for the current request (valid bits not included)
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      tag_match[w] = tag_vld[cur_addr[8:5]][w] && (tag_mdl[cur_addr[8:5]][w] == cur_addr[31:9]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access with a cycle-level memory responder; abort_beat >= 0 resets mid-refill
  task automatic access(input bit nwa, input logic we, input logic [31:0] addr,
                        input bit exp_hit, input bit exp_refill, input int exp_way,
                        input bit exp_cru, input bit exp_cpu_wr, input bit exp_mem_wr,
                        input int exp_lat, input int abort_beat);
    int cyc, beats_sent, beats_seen, done_cd, cpu_wr_n, tagwe_n, cru_n, resp_n;
    bit refill_on, gap_done, got_resp, aborted, nxt_ready, nxt_rdata, nxt_done;
    bit hexp;
    logic [32:0] mexp;
    cyc = 0; beats_sent = 0; beats_seen = 0; done_cd = -1;
    cpu_wr_n = 0; tagwe_n = 0; cru_n = 0; resp_n = 0;
    refill_on = 1'b0; gap_done = 1'b0; got_resp = 1'b0; aborted = 1'b0;
    sel_nwa  = nwa;
    cur_addr = addr;
    resp_q.push_back(exp_hit);
    if (exp_refill) mem_q.push_back({1'b0, addr & ~32'h1F});
    if (exp_mem_wr) mem_q.push_back({1'b1, addr & ~32'h3});
    @(negedge clk);
    cpu_we   = we;
    cpu_addr = addr;
    if (nwa) n_req_valid = 1'b1;
    else     m_req_valid = 1'b1;
    while (!got_resp && !aborted && cyc < 100) begin
      #1;
      if (cyc == 0) chk("req_ready", 64'(o_ready), 64'(1));
      if (o_array_we || o_tag_we) chk("array_set", 64'(o_array_set), 64'(addr[8:5]));
      if (o_array_we && !o_src_mem) begin
        cpu_wr_n++;
        chk("cpu_wr_way", 64'(o_array_way), 64'(exp_way));
        chk("cpu_wr_word", 64'(o_array_word), 64'(addr[4:2]));
      end
      if (o_array_we && o_src_mem) begin
        chk("beat_with_rdata", 64'(mem_rdata_valid), 64'(1));
        chk("beat_word", 64'(o_array_word), 64'(beats_seen));
        chk("beat_way", 64'(o_array_way), 64'(exp_way));
        chk("beat_tag_we", 64'(o_tag_we), 64'(beats_seen == 7));
        beats_seen++;
      end
      if (o_tag_we) tagwe_n++;
      if (o_cru) begin
        cru_n++;
        chk("cru_way", 64'(o_cru_way), 64'(exp_way));
      end
      if (o_mem_valid && mem_req_ready) begin
        if (mem_q.size() == 0) begin
          chk("mem_req_extra", 64'(mem_q.size()), 64'(1));
        end else begin
          mexp = mem_q.pop_front();
          chk("mem_req", 64'({o_mem_we, o_mem_addr}), 64'(mexp));
          if (!o_mem_we) refill_on = 1'b1;
          else           done_cd = 2;
        end
      end
      if (o_resp_valid) begin
        got_resp = 1'b1;
        hexp = resp_q.pop_front();
        chk("resp_hit", 64'(o_resp_hit), 64'(hexp));
        if (exp_lat >= 0) chk("resp_latency", 64'(cyc), 64'(exp_lat));
      end
      nxt_ready = o_mem_valid && !mem_req_ready;
      nxt_rdata = 1'b0;
      if (refill_on && beats_sent < 8) begin
        if (beats_sent == 4 && !gap_done) gap_done = 1'b1;
        else if (beats_sent == abort_beat) aborted = 1'b1;
        else begin
          nxt_rdata = 1'b1;
          beats_sent++;
        end
      end
      nxt_done = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        nxt_done = (done_cd == 0);
      end
      @(negedge clk);
      cyc++;
      m_req_valid     = 1'b0;
      n_req_valid     = 1'b0;
      mem_req_ready   = nxt_ready;
      mem_rdata_valid = nxt_rdata;
      mem_wr_done     = nxt_done;
    end
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(o_ready), 64'(1));
      chk("rst_array_we", 64'(o_array_we), 64'(0));
      chk("rst_mem_valid", 64'(o_mem_valid), 64'(0));
      chk("rst_mem_addr", 64'(o_mem_addr), 64'(0));
      chk("rst_array_way", 64'(o_array_way), 64'(0));
      resp_q.delete();
      mem_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
        @(negedge clk);
        #1;
        if (o_resp_valid) resp_n++;
      end
      chk("no_resp_after_reset", 64'(resp_n), 64'(0));
    end else begin
      chk("resp_seen", 64'(got_resp), 64'(1));
      chk("refill_beats", 64'(beats_seen), 64'(exp_refill ? 8 : 0));
      chk("tag_we_count", 64'(tagwe_n), 64'(exp_refill ? 1 : 0));
      chk("cpu_write_count", 64'(cpu_wr_n), 64'(exp_cpu_wr));
      chk("cru_count", 64'(cru_n), 64'(exp_cru));
      chk("mem_ops_left", 64'(mem_q.size()), 64'(0));
      #1;
      chk("resp_single_pulse", 64'(o_resp_valid), 64'(0));
      chk("back_to_idle", 64'(o_ready), 64'(1));
    end
    resp_q.delete();
    mem_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; m_req_valid = 1'b0; n_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    flush = 1'b0; replace_way = 2'd3; mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
    mem_wr_done = 1'b0; sel_nwa = 1'b0; cur_addr = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk("reset_ready", 64'(o_ready), 64'(1));
    chk("reset_resp", 64'(o_resp_valid), 64'(0));
    chk("reset_mem_valid", 64'(o_mem_valid), 64'(0));
    chk("reset_strobes", 64'({o_array_we, o_tag_we, o_cru}), 64'(0));
    chk("reset_array_set", 64'(o_array_set), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Cold read miss into set 2 (invalid way 0 beats replace_way 3), then the hit
    access(0, 0, 32'h0000_0040, 0, 1, 0, 1, 0, 0, 14, -1);
    access(0, 0, 32'h0000_0040, 1, 0, 0, 1, 0, 0, 2, -1);
    // Write hit: array write word 1, then write-through at 0x44
    access(0, 1, 32'h0000_0044, 1, 0, 0, 1, 1, 1, 6, -1);
    // Fill remaining ways of set 2, then evict through replace_way
    access(0, 0, 32'h0000_0240, 0, 1, 1, 1, 0, 0, 14, -1);
    access(0, 0, 32'h0000_0440, 0, 1, 2, 1, 0, 0, 14, -1);
    access(0, 0, 32'h0000_0640, 0, 1, 3, 1, 0, 0, 14, -1);
    replace_way = 2'd2;
    access(0, 0, 32'h0000_0840, 0, 1, 2, 1, 0, 0, 14, -1);
    access(0, 0, 32'h0000_0840, 1, 0, 2, 1, 0, 0, 2, -1);
    // Write-allocate miss: refill, replayed write hit, write-through
    access(0, 1, 32'h0000_108C, 0, 1, 0, 1, 1, 1, 18, -1);
    // No-allocate write miss: straight write-through only
    access(1, 1, 32'h0000_0044, 0, 0, 0, 0, 0, 1, 6, -1);

    // Flush wins over a same-cycle request
    sel_nwa = 1'b0;
    @(negedge clk);
    cur_addr = 32'h0000_0040; cpu_addr = 32'h0000_0040; cpu_we = 1'b0;
    flush = 1'b1; m_req_valid = 1'b1;
    #1;
    chk("flush_ready_low", 64'(o_ready), 64'(0));
    @(negedge clk);
    flush = 1'b0; m_req_valid = 1'b0;
    #1;
    chk("flush_not_accepted", 64'(o_ready), 64'(1));
    access(0, 0, 32'h0000_0040, 0, 1, 0, 1, 0, 0, 14, -1);

    // Reset on refill beat 3, then the same line must still miss
    access(0, 0, 32'h0000_0240, 0, 1, 1, 1, 0, 0, -1, 3);
    access(0, 0, 32'h0000_0240, 0, 1, 0, 1, 0, 0, 14, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
